ball_motion: RTL
================

Name: ball_motion

Overview:
- Ball position stage feeding the direction-control stage.
- Holds ball X/Y, steps them once per frame according to the current horizontal/vertical direction bits, and generates the per-pixel ball window strobes (o_HBall, o_VBall) that the direction stage uses for edge bounces and that the renderer uses for drawing.
- Includes a serve state machine: the ball is parked at centre after reset or a miss, then released after a fixed number of frames.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- BALL_SIZE, 8, ball edge length in pixels/lines.
- SPEED, 2, pixels moved per frame on each axis (1..BALL_SIZE).
- SERVE_FRAMES, 60, frames the ball is held at centre before moving.
- CW, 10, width of the counter and position buses.

Ports:
- i_Clk  in  1  pixel clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_HCount  in  CW  current pixel column from the sync generator.
- i_VCount  in  CW  current line from the sync generator.
- i_Frame_Tick  in  1  one-cycle pulse at the first cycle of vertical blank.
- i_HDir  in  1  0 = right (+X), 1 = left (−X).
- i_VDir  in  1  0 = down (+Y), 1 = up (−Y).
- i_Miss  in  1  one-cycle pulse: ball lost; return to serve.
- o_X  out  CW  ball left column.
- o_Y  out  CW  ball top line.
- o_HBall  out  1  i_HCount within [o_X, o_X+BALL_SIZE).
- o_VBall  out  1  i_VCount within [o_Y, o_Y+BALL_SIZE).
- o_Ball  out  1  o_HBall AND o_VBall.
- o_Serving  out  1  high while in the SERVE state.

Behaviour:
- One clock domain: all state updates on rising i_Clk. Reset is synchronous, active-high.
- Reset values:
  - o_X = X_CENTRE = (H_ACTIVE−BALL_SIZE)/2 = 316.
  - o_Y = Y_CENTRE = (V_ACTIVE−BALL_SIZE)/2 = 236.
  - State = SERVE, frame counter = 0, o_Serving = 1.
  - o_HBall = o_VBall = o_Ball = 0.
- States:
  - SERVE: position forced to centre. Each i_Frame_Tick increments the frame counter. On the tick that makes the count equal SERVE_FRAMES, go to MOVE and clear the counter. Position does not step on that tick.
  - MOVE: on each i_Frame_Tick, both axes step by SPEED, with X and Y updated in the same cycle.
- Step and saturation rules:
  - X range is [0, X_MAX], X_MAX = H_ACTIVE−BALL_SIZE+1 = 633. Y range is [0, Y_MAX], Y_MAX = V_ACTIVE−BALL_SIZE+1 = 473.
  - Stepping toward 0 saturates at 0. Stepping toward MAX saturates at MAX.
  - At MAX the ball covers the first blank pixel/line, so the window overlaps blank and the downstream bounce fires. At 0 the window covers column/line 0, coinciding with the line/frame reset pulse.
  - Arithmetic is CW+1 bits wide to detect underflow and overflow before clamping; no wrap-around is permitted.
- Latency:
  - o_X/o_Y update one cycle after i_Frame_Tick.
  - o_HBall/o_VBall/o_Ball are registered: they reflect i_HCount/i_VCount from the previous cycle, the same one-cycle latency as the sync generator's blank outputs.
- i_Miss:
  - From any state, the next cycle gives SERVE, centre position and counter 0.
  - i_Miss in the same cycle as i_Frame_Tick: i_Miss wins and no step occurs.
  - i_Reset has priority over everything.
- Direction bits are sampled only on the i_Frame_Tick cycle. Changes at other times have no effect until the next tick.
- Reset asserted mid-frame: outputs return to reset values on the next edge. The window strobes are 0 for that cycle, then track the centre position.

Decomposition:
- Shared package pong_pkg holds:
  - direction encodings RIGHT/LEFT/UP/DOWN (0/1/1/0);
  - state enum {SERVE, MOVE};
  - derived constants X_CENTRE, Y_CENTRE, X_MAX, Y_MAX.
- One natural sub-module, ball_axis, instantiated twice (X and Y). It contains the position register, the saturating ±SPEED step, the centre-load and the registered window compare.
- The top level holds the serve FSM, the frame counter and the AND for o_Ball.

Test Plan:
- Reset: assert i_Reset for 1 cycle. Required: o_X = 316, o_Y = 236, o_Serving = 1. Then give 59 ticks: o_Serving stays 1. On the 60th tick: o_Serving = 0 and o_X is still 316.
- Step: in MOVE with HDir = 0, VDir = 1 at (316,236), give one tick. Required: (318,234) one cycle later. Toggle HDir between ticks: the change is applied only on the next tick.
- Saturation: from X = 632, HDir = 0, give one tick. Required: X = 633. A further tick keeps X = 633. When HCount = 640, o_HBall = 1 on the following cycle. Same check for Y = 0 moving up.
- Window: X = 100, sweep HCount 99..108. Required: o_HBall high for exactly the 8 cycles following HCount = 100..107. o_Ball high only where the VBall window also matches.
- Miss priority: i_Miss and i_Frame_Tick together at (400,300). Required: next cycle (316,236), o_Serving = 1, counter 0.
- Mid-operation reset: i_Reset during an active ball window. Required: o_Ball = 0 next cycle, and position at centre.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared pong geometry, serve timing, direction encodings and ball state enum
package pong_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int BALL_SIZE = 8;
  localparam int SPEED = 2;
  localparam int SERVE_FRAMES = 60;
  localparam int CW = 10;
  localparam int X_CENTRE = (H_ACTIVE - BALL_SIZE) / 2;
  localparam int Y_CENTRE = (V_ACTIVE - BALL_SIZE) / 2;
  localparam int X_MAX = H_ACTIVE - BALL_SIZE + 1;
  localparam int Y_MAX = V_ACTIVE - BALL_SIZE + 1;
  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic RIGHT = 1'b0;
  localparam logic LEFT = 1'b1;
  localparam logic UP = 1'b1;
  localparam logic DOWN = 1'b0;
  typedef enum logic {SERVE, MOVE} state_t;
endpackage

// File: rtl/ball_axis.sv
// ball_axis: one ball axis (clk, rst, load_i centre, step_i, dec_i, count_i -> pos_o, registered win_o)
module ball_axis
  import pong_pkg::*;
#(
  parameter int CENTRE = 0,
  parameter int MAX = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  logic          dec_i,
  input  logic [CW-1:0] count_i,
  output logic [CW-1:0] pos_o,
  output logic          win_o
);
  logic [CW-1:0] pos_q, pos_d;
  logic win_q, win_d;
  logic [CW:0] inc_w, dec_w;
  always_comb begin
    inc_w = {1'b0, pos_q} + (CW+1)'(SPEED);
    dec_w = {1'b0, pos_q} - (CW+1)'(SPEED);
    pos_d = load_i ? CW'(CENTRE) : !step_i ? pos_q :
            dec_w == dec_w && dec_i ? (dec_w[CW] ? '0 : dec_w[CW-1:0]) :
            (inc_w > (CW+1)'(MAX) ? CW'(MAX) : inc_w[CW-1:0]);
    win_d = count_i >= pos_q && {1'b0, count_i} < {1'b0, pos_q} + (CW+1)'(BALL_SIZE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= CW'(CENTRE);
      win_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      win_q <= win_d;
    end
  end
  assign pos_o = pos_q;
  assign win_o = win_q;
endmodule

// File: rtl/ball_motion.sv
// ball_motion: serve FSM + per-frame ball stepping (i_Clk, i_Reset, counts, tick, dirs, miss -> o_X/o_Y, window strobes, o_Serving)
module ball_motion
  import pong_pkg::*;
(
  input  logic          i_Clk,
  input  logic          i_Reset,
  input  logic [CW-1:0] i_HCount,
  input  logic [CW-1:0] i_VCount,
  input  logic          i_Frame_Tick,
  input  logic          i_HDir,
  input  logic          i_VDir,
  input  logic          i_Miss,
  output logic [CW-1:0] o_X,
  output logic [CW-1:0] o_Y,
  output logic          o_HBall,
  output logic          o_VBall,
  output logic          o_Ball,
  output logic          o_Serving
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic serve_tick, last, step, load;
  always_comb begin
    serve_tick = state_q == SERVE && i_Frame_Tick;
    last = cnt_q == CNT_W'(SERVE_FRAMES - 1);
    state_d = i_Miss ? SERVE : (serve_tick && last) ? MOVE : state_q;
    cnt_d = i_Miss ? '0 : serve_tick ? (last ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
    step = state_q == MOVE && i_Frame_Tick && !i_Miss;
    load = state_q == SERVE || i_Miss;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= SERVE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  ball_axis #(.CENTRE(X_CENTRE), .MAX(X_MAX)) u_x (
    .clk(i_Clk), .rst(i_Reset), .load_i(load), .step_i(step), .dec_i(i_HDir == LEFT),
    .count_i(i_HCount), .pos_o(o_X), .win_o(o_HBall)
  );
  ball_axis #(.CENTRE(Y_CENTRE), .MAX(Y_MAX)) u_y (
    .clk(i_Clk), .rst(i_Reset), .load_i(load), .step_i(step), .dec_i(i_VDir == UP),
    .count_i(i_VCount), .pos_o(o_Y), .win_o(o_VBall)
  );
  assign o_Ball = o_HBall & o_VBall;
  assign o_Serving = state_q == SERVE;
endmodule
